// File: rtl/shift_exec_unit_pkg.sv
// Shared processor definitions for the shift execution unit:
// operation encodings and the destination-tag width.
package shift_exec_unit_pkg;

    localparam int TAG_W = 5;

    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROL = 3'b011,
        OP_ROR = 3'b100
    } op_e;

endpackage

// File: rtl/barrel_shifter.sv
// Logarithmic barrel shifter: right shift (logical or arithmetic), or left
// shift implemented by bit-reversing around the right-shift network.
module barrel_shifter #(
    parameter int WIDTH       = 32,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic [WIDTH-1:0]       i_data,
    input  logic [SHIFT_WIDTH-1:0] i_amt,
    input  logic                   i_left,
    input  logic                   i_arith,
    output logic [WIDTH-1:0]       o_data
);

    localparam logic [WIDTH-1:0] Ones = '1;

    logic [WIDTH-1:0] w_rev_in;
    logic [WIDTH-1:0] w_rev_out;
    logic [WIDTH-1:0] w_shift;
    logic             w_fill;

    // Arithmetic fill only makes sense for right shifts.
    assign w_fill = i_arith & ~i_left & i_data[WIDTH-1];

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_rev_in[i] = i_data[WIDTH-1-i];
        end
    end

    always_comb begin
        w_shift = i_left ? w_rev_in : i_data;
        for (int s = 0; s < SHIFT_WIDTH; s++) begin
            if (i_amt[s]) begin
                w_shift = (w_shift >> (1 << s)) | (w_fill ? ~(Ones >> (1 << s)) : '0);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_rev_out[i] = w_shift[WIDTH-1-i];
        end
    end

    assign o_data = i_left ? w_rev_out : w_shift;

endmodule

// File: rtl/shift_exec_unit.sv
// Two-stage shift/rotate execution unit with valid/ready handshaking on both
// sides, flush, and carry/zero/illegal flags.
module shift_exec_unit
    import shift_exec_unit_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_op,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SHIFT_WIDTH-1:0] in_amt,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_result,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   out_carry,
    output logic                   out_zero,
    output logic                   out_illegal
);

    // Stage 1: captured request
    logic                   r_v1;
    logic [2:0]             r_op;
    logic [WIDTH-1:0]       r_data;
    logic [SHIFT_WIDTH-1:0] r_amt;
    logic [TAG_W-1:0]       r_tag1;

    // Stage 2: result and flags
    logic                   r_v2;
    logic [WIDTH-1:0]       r_result;
    logic [TAG_W-1:0]       r_tag2;
    logic                   r_carry;
    logic                   r_illegal;

    logic                   w_adv1;
    logic                   w_adv2;
    logic [SHIFT_WIDTH-1:0] w_inv_amt;
    logic [SHIFT_WIDTH-1:0] w_carry_idx;
    logic                   w_main_left;
    logic                   w_main_arith;
    logic                   w_rot_left;
    logic [WIDTH-1:0]       w_main;
    logic [WIDTH-1:0]       w_rot;
    logic [WIDTH-1:0]       w_result;
    logic                   w_carry;
    logic                   w_illegal;

    assign w_adv2   = ~r_v2 | out_ready;
    assign w_adv1   = ~r_v1 | w_adv2;
    assign in_ready = w_adv1 & ~rst;

    // WIDTH - amt, modulo WIDTH; relies on WIDTH == 2**SHIFT_WIDTH.
    assign w_inv_amt = -r_amt;

    assign w_main_left  = (r_op == OP_SLL) || (r_op == OP_ROL);
    assign w_main_arith = (r_op == OP_SRA);
    assign w_rot_left   = (r_op == OP_ROR);

    barrel_shifter #(
        .WIDTH       (WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_main_shift (
        .i_data  (r_data),
        .i_amt   (r_amt),
        .i_left  (w_main_left),
        .i_arith (w_main_arith),
        .o_data  (w_main)
    );

    // Opposite-direction term for rotates; at amt 0 it shifts by 0 and the
    // OR with the main term still yields the operand unchanged.
    barrel_shifter #(
        .WIDTH       (WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_rot_shift (
        .i_data  (r_data),
        .i_amt   (w_inv_amt),
        .i_left  (w_rot_left),
        .i_arith (1'b0),
        .o_data  (w_rot)
    );

    assign w_carry_idx = (r_op == OP_SLL) ? w_inv_amt : (r_amt - 1'b1);

    always_comb begin
        w_result  = r_data;
        w_carry   = 1'b0;
        w_illegal = 1'b0;
        case (r_op)
            OP_SLL, OP_SRL, OP_SRA: begin
                w_result = w_main;
                w_carry  = (r_amt != '0) & r_data[w_carry_idx];
            end
            OP_ROL, OP_ROR: begin
                w_result = w_main | w_rot;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1      <= 1'b0;
            r_op      <= '0;
            r_data    <= '0;
            r_amt     <= '0;
            r_tag1    <= '0;
            r_v2      <= 1'b0;
            r_result  <= '0;
            r_tag2    <= '0;
            r_carry   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            if (w_adv1) begin
                r_v1 <= in_valid;
                if (in_valid) begin
                    r_op   <= in_op;
                    r_data <= in_data;
                    r_amt  <= in_amt;
                    r_tag1 <= in_tag;
                end
            end
            if (w_adv2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_result  <= w_result;
                    r_tag2    <= r_tag1;
                    r_carry   <= w_carry;
                    r_illegal <= w_illegal;
                end
            end
        end
    end

    assign out_valid   = r_v2;
    assign out_result  = r_result;
    assign out_tag     = r_tag2;
    assign out_carry   = r_carry;
    assign out_illegal = r_illegal;
    // Qualified by valid so the flag reads 0 out of reset and between results.
    assign out_zero    = r_v2 & (r_result == '0);

endmodule

// File: tb/tb_shift_exec_unit.sv
// Self-checking bench for shift_exec_unit: directed cases plus randomized
// traffic scored against a transaction-level reference model.
module tb_shift_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_data;
    logic [4:0]  in_amt;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        out_carry;
    logic        out_zero;
    logic        out_illegal;

    always #5 clk = ~clk;

    shift_exec_unit #(
        .WIDTH       (32),
        .SHIFT_WIDTH (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_data     (in_data),
        .in_amt      (in_amt),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .out_carry   (out_carry),
        .out_zero    (out_zero),
        .out_illegal (out_illegal)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        carry;
        logic        zero;
        logic        ill;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic        last_ov;
    logic [40:0] last_obs;

    // Reference: direct arithmetic on the operand.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] d,
                                   input logic [4:0] a, input logic [4:0] t);
        exp_t e;
        int   n;
        n       = int'(a);
        e.res   = d;
        e.tag   = t;
        e.carry = 1'b0;
        e.ill   = 1'b0;
        case (op)
            3'd0: begin e.res = d << n; if (n > 0) e.carry = d[32-n]; end
            3'd1: begin e.res = d >> n; if (n > 0) e.carry = d[n-1]; end
            3'd2: begin e.res = $signed(d) >>> n; if (n > 0) e.carry = d[n-1]; end
            3'd3: e.res = (d << n) | (d >> (32 - n));
            3'd4: e.res = (d >> n) | (d << (32 - n));
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    // One clock cycle: drive at negedge, check handshake/outputs, update model at posedge.
    task automatic step(input logic v, input logic [2:0] op, input logic [31:0] d,
                        input logic [4:0] a, input logic [4:0] t, input logic ordy,
                        input logic fl, input logic r);
        exp_t e;
        logic exp_ir;
        logic acc;
        @(negedge clk);
        in_valid  = v;
        in_op     = op;
        in_data   = d;
        in_amt    = a;
        in_tag    = t;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        #1;
        exp_ir = !r && !(exp_q.size() >= 2 && !ordy);
        total++;
        if (in_ready !== exp_ir) begin
            bad++;
            $display("FAIL in_ready got=%b want=%b", in_ready, exp_ir);
        end
        last_ov  = out_valid;
        last_obs = {out_valid, out_result, out_tag, out_carry, out_zero, out_illegal};
        if (exp_q.size() == 0) begin
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL spurious_output got out_valid=%b tag=%0d want out_valid=0",
                         out_valid, out_tag);
            end
        end else if (out_valid === 1'b1 && ordy) begin
            e = exp_q.pop_front();
            total++;
            if ({out_result, out_tag, out_carry, out_zero, out_illegal} !== e) begin
                bad++;
                $display("FAIL scoreboard got res=%h tag=%0d c=%b z=%b il=%b want res=%h tag=%0d c=%b z=%b il=%b",
                         out_result, out_tag, out_carry, out_zero, out_illegal,
                         e.res, e.tag, e.carry, e.zero, e.ill);
            end
        end
        acc = v && exp_ir && !fl;
        @(posedge clk);
        if (fl || r) exp_q.delete();
        if (acc) exp_q.push_back(model(op, d, a, t));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, $urandom, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_data = '0;
        in_amt = '0; in_tag = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        total++;
        if ({out_result, out_tag, out_carry, out_zero, out_illegal} !== 41'd0) begin
            bad++;
            $display("FAIL reset_outputs got res=%h tag=%0d c=%b z=%b il=%b want all 0",
                     out_result, out_tag, out_carry, out_zero, out_illegal);
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  t_op  [7];
        logic [31:0] t_d   [7];
        logic [4:0]  t_a   [7];
        logic [31:0] t_res [7];
        logic        t_c   [7];
        logic        t_z   [7];
        logic        t_il  [7];
        t_op  = '{3'b010, 3'b000, 3'b001, 3'b100, 3'b011, 3'b111, 3'b001};
        t_d   = '{32'h80000010, 32'h80000001, 32'h12345678, 32'h00000001,
                  32'h80000000, 32'hCAFEF00D, 32'h00000001};
        t_a   = '{5'd4, 5'd1, 5'd0, 5'd1, 5'd4, 5'd3, 5'd1};
        t_res = '{32'hF8000001, 32'h00000002, 32'h12345678, 32'h80000000,
                  32'h00000008, 32'hCAFEF00D, 32'h00000000};
        t_c   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        t_z   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        t_il  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_op = t_op[i]; in_data = t_d[i]; in_amt = t_a[i];
            in_tag = 5'(i + 20); out_ready = 1'b1; flush = 1'b0; rst = 1'b0;
            #1;
            total++;
            if (in_ready !== 1'b1) begin
                bad++; $display("FAIL directed_accept case=%0d got in_ready=%b want=1", i, in_ready);
            end
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            total++;
            if (out_valid !== 1'b0) begin
                bad++; $display("FAIL directed_early case=%0d got out_valid=%b want=0", i, out_valid);
            end
            @(negedge clk);
            #1;
            total++;
            if (out_valid !== 1'b1 || out_result !== t_res[i] || out_carry !== t_c[i] ||
                out_zero !== t_z[i] || out_illegal !== t_il[i] || out_tag !== 5'(i + 20)) begin
                bad++;
                $display("FAIL directed case=%0d got v=%b res=%h c=%b z=%b il=%b tag=%0d want v=1 res=%h c=%b z=%b il=%b tag=%0d",
                         i, out_valid, out_result, out_carry, out_zero, out_illegal, out_tag,
                         t_res[i], t_c[i], t_z[i], t_il[i], i + 20);
            end
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 10; k++) begin
            step(k < 8, 3'($urandom_range(0, 4)), $urandom, 5'($urandom), 5'(k), 1'b1, 1'b0, 1'b0);
            if (k >= 2) begin
                total++;
                if (last_ov !== 1'b1) begin
                    bad++; $display("FAIL b2b_stream slot=%0d got out_valid=%b want=1", k, last_ov);
                end
            end
        end
        idle(3);
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL b2b_drain got pending=%0d want=0", exp_q.size());
        end
    endtask

    task automatic test_stall();
        logic [40:0] snap;
        step(1'b1, 3'd0, $urandom, 5'($urandom), 5'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'd2, $urandom, 5'($urandom), 5'd2, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 3'd1, $urandom, 5'($urandom), 5'd3, 1'b0, 1'b0, 1'b0);
            if (k == 0) begin
                snap = last_obs;
                total++;
                if (snap[40] !== 1'b1) begin
                    bad++; $display("FAIL stall_full got out_valid=%b want=1", snap[40]);
                end
            end else begin
                total++;
                if (last_obs !== snap) begin
                    bad++; $display("FAIL stall_stable got=%h want=%h", last_obs, snap);
                end
            end
        end
        idle(4);
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL stall_release got pending=%0d want=0", exp_q.size());
        end
    endtask

    task automatic test_kill(input logic use_rst);
        step(1'b1, 3'd3, $urandom, 5'($urandom), 5'd4, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'd4, $urandom, 5'($urandom), 5'd5, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'd0, $urandom, 5'($urandom), 5'd6, 1'b1, !use_rst, use_rst);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL kill rst=%b got out_valid=%b want=0", use_rst, out_valid);
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 3'd0, 32'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
            total++;
            if (last_ov !== 1'b0) begin
                bad++; $display("FAIL kill_ghost rst=%b got out_valid=%b want=0", use_rst, last_ov);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        for (int k = 0; k < 400; k++) begin
            d = $urandom;
            if ($urandom_range(0, 15) == 0) d = 32'd0;
            if ($urandom_range(0, 15) == 0) d = 32'hFFFFFFFF;
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), d, 5'($urandom),
                 5'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, 1'b0);
        end
        idle(6);
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL random_drain got pending=%0d want=0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_kill(1'b0);
        test_kill(1'b1);
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_exec_unit.md
SHIFT_EXEC_UNIT -- requirements
Module: shift_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits.
REQ-002 SHALL have parameter SHIFT_WIDTH, default 5, shift-amount width (log2 WIDTH).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port flush, input, 1, synchronous pipeline kill.
REQ-006 SHALL have port in_valid, input, 1, upstream request valid.
REQ-007 SHALL have port in_ready, output, 1, unit can accept this cycle.
REQ-008 SHALL have port in_op, input, 3, operation: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others illegal.
REQ-009 SHALL have port in_data, input, WIDTH, operand.
REQ-010 SHALL have port in_amt, input, SHIFT_WIDTH, shift amount.
REQ-011 SHALL have port in_tag, input, 5, destination-register tag carried with the op.
REQ-012 SHALL have port out_valid, output, 1, result valid.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-014 SHALL have port out_result, output, WIDTH, shifted/rotated value.
REQ-015 SHALL have port out_tag, output, 5, tag of the result.
REQ-016 SHALL have port out_carry, output, 1, last bit shifted out.
REQ-017 SHALL have port out_zero, output, 1, out_result equals zero.
REQ-018 SHALL have port out_illegal, output, 1, op code was illegal.

Function
REQ-019 SHALL be a two-stage pipeline: S1 registers op/data/amt/tag; S2 registers result and flags.
REQ-020 SHALL accept a request on a cycle with in_valid and in_ready both high; out_valid rises two cycles later if unstalled.
REQ-021 SHALL sustain one result per cycle while out_ready is held high.
REQ-022 SHALL compute adv2 = !v2 | out_ready, adv1 = !v1 | adv2, and in_ready = adv1 (no combinational path from in_valid to in_ready).
REQ-023 SHALL hold S2 contents and out_* stable while out_valid and !out_ready.
REQ-024 SHALL fill with 0 for SLL/SRL, and with data[WIDTH-1] for SRA.
REQ-025 SHALL compute ROL as (d<<a)|(d>>(WIDTH-a)) and ROR as (d>>a)|(d<<(WIDTH-a)); amt 0 returns d unchanged.
REQ-026 SHALL set out_carry to d[WIDTH-a] for SLL and to d[a-1] for SRL/SRA when a>0, and to 0 when a=0 or for rotates.
REQ-027 SHALL for an illegal op pass in_data through, set out_illegal=1 and out_carry=0, and still handshake normally.
REQ-028 SHALL derive out_zero from the S2-registered result.
REQ-029 SHALL on flush clear v1 and v2 next edge; flush has priority over a same-cycle accept, which is dropped.
REQ-030 SHALL treat a simultaneous S2 drain and S1 advance as one transfer, with no bubble and no duplicate.

Reset
REQ-031 SHALL while rst is high clear v1, v2, out_valid, out_result, out_tag, out_carry, out_zero and out_illegal to 0.
REQ-032 SHALL force in_ready to 0 during reset and make it 1 on the first cycle after reset.
REQ-033 SHALL discard any in-flight operation on reset mid-operation, with no output after reset deasserts.

Structure
REQ-034 SHALL take op encodings (OP_SLL..OP_ROR) and the TAG_W=5 constant from the shared processor package.
REQ-035 SHALL instantiate the existing barrel_shifter module for SLL/SRL/SRA, with a second instance for the opposite-direction rotate term.

Verification
REQ-036 SRA: in_data=0x80000010, amt=4 -> out_result=0xF8000001, carry=0, zero=0, two cycles after accept.
REQ-037 SLL: in_data=0x80000001, amt=1 -> result=0x00000002, carry=1; SRL with amt=0 -> result=data, carry=0.
REQ-038 ROR: 0x00000001 amt=1 -> 0x80000000; ROL: 0x80000000 amt=4 -> 0x00000008; illegal op=111 -> data passthrough, out_illegal=1.
REQ-039 Back-to-back stream of 8 ops with out_ready=1 -> 8 consecutive out_valid cycles, tags in order.
REQ-040 out_ready low 3 cycles with pipeline full -> in_ready=0, out_* stable, no loss or duplication after release.
REQ-041 flush or rst asserted with both stages valid -> out_valid=0 next cycle; op accepted in the same cycle never appears.
